// File: rtl/axi2fifo_if.sv
// Bundles the AXI-Stream input beat signals and the memory-word output side of axi2fifo.
// master = beat source / word sink; slave = the repacking block.
interface axi2fifo_if;
  logic         tvalid;
  logic         tready;
  logic [255:0] tdata;
  logic [31:0]  tstrb;
  logic [127:0] tuser;
  logic         tlast;
  logic         output_enable;
  logic [201:0] dout;
  logic         dout_valid;
  logic [4:0]   oq;

  modport master (
    output tvalid, tdata, tstrb, tuser, tlast, output_enable,
    input  tready, dout, dout_valid, oq
  );

  modport slave (
    input  tvalid, tdata, tstrb, tuser, tlast, output_enable,
    output tready, dout, dout_valid, oq
  );
endinterface

// File: rtl/axi2fifo.sv
// Repacks 256-bit AXI-Stream beats into 202-bit memory words (header + 24-byte data words).
// state   | meaning
// S_FIRST | next accepted beat starts a new packet (header is generated for it)
// S_BODY  | inside a packet, next accepted beat continues the byte stream
module axi2fifo (
  input  logic      clk,
  input  logic      reset,
  axi2fifo_if.slave bus
);

  typedef enum logic {S_FIRST, S_BODY} state_t;

  state_t         state_q, state_d;
  logic           hdr_q, hdr_d;
  logic [127:0]   tuser_q, tuser_d;
  logic [447:0]   buf_q, buf_d;
  logic [5:0]     cnt_q, cnt_d;
  logic           last_q, last_d;
  logic [1:0]     phase_q, phase_d;
  logic [201:0]   dout_q, dout_d;
  logic [4:0]     oq_q, oq_d;

  logic [1:0]     data_pend;
  logic [2:0]     pend;
  logic           emit;
  logic           accept;
  logic           tready;
  logic [5:0]     take;
  logic           word_last;
  logic [2:0]     tag;
  logic [201:0]   hdr_word;
  logic [201:0]   data_word;
  logic [201:0]   word;
  logic [5:0]     strb_ones;
  logic [5:0]     beat_bytes;
  logic [255:0]   beat_masked;

  // Buffer holds the unsent packet bytes, oldest byte in buf_q[7:0]; bytes above cnt_q are zero.
  always_comb begin
    data_pend = 2'd0;
    if (cnt_q >= 6'd48) begin
      data_pend = 2'd2;
    end else if (cnt_q >= 6'd24) begin
      data_pend = 2'd1;
    end
    if (last_q && (cnt_q != 6'd0) && (cnt_q != 6'd24) && (cnt_q != 6'd48)) begin
      data_pend = data_pend + 2'd1;
    end
  end

  assign pend      = {2'b00, hdr_q} + {1'b0, data_pend};
  assign emit      = bus.output_enable && (pend != 3'd0);
  assign tready    = reset && ((pend == 3'd0) || ((pend == 3'd1) && bus.output_enable));
  assign accept    = bus.tvalid && tready;

  assign take      = (cnt_q > 6'd24) ? 6'd24 : cnt_q;
  assign word_last = last_q && (cnt_q <= 6'd24);
  assign tag       = {1'b0, phase_q} + 3'd1;
  assign hdr_word  = {64'd0, tuser_q, 5'd16, 3'd0, 2'b00};
  assign data_word = {buf_q[191:0], take[4:0], tag, word_last, 1'b0};
  assign word      = hdr_q ? hdr_word : data_word;

  always_comb begin
    strb_ones   = 6'd0;
    beat_masked = '0;
    for (int i = 0; i < 32; i++) begin
      strb_ones = strb_ones + {5'd0, bus.tstrb[i]};
    end
    beat_bytes = bus.tlast ? strb_ones : 6'd32;
    for (int i = 0; i < 32; i++) begin
      beat_masked[8*i +: 8] = (6'(i) < beat_bytes) ? bus.tdata[8*i +: 8] : 8'h00;
    end
  end

  // Emission consumes from the buffer first, so an accepted beat lands right after what remains.
  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    tuser_d = tuser_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    phase_d = phase_q;
    dout_d  = dout_q;
    oq_d    = oq_q;

    if (emit) begin
      dout_d = word;
      if (hdr_q) begin
        hdr_d = 1'b0;
        oq_d  = {tuser_q[25] | tuser_q[27] | tuser_q[29] | tuser_q[31],
                 tuser_q[30], tuser_q[28], tuser_q[26], tuser_q[24]};
      end else begin
        buf_d   = buf_q >> 192;
        cnt_d   = cnt_q - take;
        phase_d = phase_q + 2'd1;
      end
    end

    if (accept) begin
      buf_d  = buf_d | ({192'd0, beat_masked} << {cnt_d, 3'b000});
      cnt_d  = cnt_d + beat_bytes;
      last_d = bus.tlast;
      if (state_q == S_FIRST) begin
        hdr_d   = 1'b1;
        tuser_d = bus.tuser;
        phase_d = 2'd0;
      end
      state_d = bus.tlast ? S_FIRST : S_BODY;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FIRST;
      hdr_q   <= 1'b0;
      tuser_q <= '0;
      buf_q   <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      phase_q <= '0;
      dout_q  <= '0;
      oq_q    <= '0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      tuser_q <= tuser_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      phase_q <= phase_d;
      dout_q  <= dout_d;
      oq_q    <= oq_d;
    end
  end

  assign bus.tready     = tready;
  assign bus.dout_valid = emit;
  assign bus.dout       = emit ? word : dout_q;
  assign bus.oq         = oq_q;

endmodule

// File: tb/tb_axi2fifo.sv
// Self-checking bench for axi2fifo: directed packets plus randomized traffic against a byte-stream model.
module tb_axi2fifo;

  logic clk = 1'b0;
  logic reset;

  axi2fifo_if bus ();

  axi2fifo dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           failures = 0;
  int           words_seen = 0;
  logic [201:0] exp_q[$];
  logic [201:0] last_dout;
  logic         acc;
  logic [255:0] beat_data [8];
  int           nb;
  int           last_bytes;
  logic [127:0] user;

  task automatic chk(input string tag, input logic [201:0] obs, input logic [201:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] oq_exp(input logic [127:0] u);
    logic [4:0] o;
    for (int i = 0; i < 4; i++) o[i] = u[24 + 2*i];
    o[4] = u[25] | u[27] | u[29] | u[31];
    return o;
  endfunction

  // One clock: check outputs at the falling edge, then return just after the rising edge.
  task automatic cycle();
    logic [201:0] e;
    @(negedge clk);
    if (bus.dout_valid === 1'b1) begin
      words_seen++;
      chk("valid_without_oe", {201'd0, bus.output_enable}, 202'd1);
      chk("extra_word", {201'd0, (exp_q.size() > 0)}, 202'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("word", bus.dout, e);
      end
      last_dout = bus.dout;
    end else begin
      chk("dout_hold", bus.dout, last_dout);
    end
    acc = (bus.tvalid === 1'b1) && (bus.tready === 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic setup_pkt(input int nbeats, input int lastb, input logic [127:0] u);
    nb = nbeats;
    last_bytes = lastb;
    user = u;
    for (int b = 0; b < nbeats; b++)
      for (int w = 0; w < 8; w++) beat_data[b][32*w +: 32] = $urandom();
  endtask

  // Reference: the packet as a byte stream, cut into 24-byte words after a header.
  task automatic model_push();
    logic [7:0]   bytes[$];
    logic [191:0] pl;
    int           pos, n, k, total;
    for (int b = 0; b < nb; b++) begin
      n = (b == nb - 1) ? last_bytes : 32;
      for (int i = 0; i < n; i++) bytes.push_back(beat_data[b][8*i +: 8]);
    end
    exp_q.push_back({64'd0, user, 5'd16, 3'd0, 2'b00});
    total = bytes.size();
    pos = 0;
    k = 0;
    while (pos < total) begin
      n = (total - pos > 24) ? 24 : total - pos;
      pl = '0;
      for (int j = 0; j < n; j++) pl[8*j +: 8] = bytes[pos + j];
      exp_q.push_back({pl, 5'(n), 3'(k % 4 + 1), (pos + n == total), 1'b0});
      pos += n;
      k++;
    end
  endtask

  task automatic drive(input int start, input int oe_pct, input int tv_pct, input int stop_at);
    int b, guard;
    b = start;
    guard = 0;
    while (b < stop_at && guard < 3000) begin
      bus.tdata  = beat_data[b];
      bus.tlast  = (b == nb - 1);
      bus.tstrb  = (b == nb - 1) ? (32'hFFFF_FFFF >> (32 - last_bytes)) : 32'hFFFF_FFFF;
      bus.tuser  = (b == 0) ? user : {$urandom(), $urandom(), $urandom(), $urandom()};
      bus.tvalid = ($urandom_range(99) < tv_pct);
      bus.output_enable = ($urandom_range(99) < oe_pct);
      cycle();
      if (acc) b++;
      guard++;
    end
    bus.tvalid = 1'b0;
    chk("beat_budget", 202'(b), 202'(stop_at));
  endtask

  task automatic drain(input int oe_pct);
    int g;
    g = 0;
    bus.tvalid = 1'b0;
    while (exp_q.size() != 0 && g < 1000) begin
      bus.output_enable = ($urandom_range(99) < oe_pct);
      cycle();
      g++;
    end
    bus.output_enable = 1'b1;
    repeat (3) cycle();
    chk("drain_empty", 202'(exp_q.size()), 202'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.tvalid = 1'b0;
    bus.tdata = '0;
    bus.tstrb = '0;
    bus.tuser = '0;
    bus.tlast = 1'b0;
    bus.output_enable = 1'b0;
    last_dout = '0;
    acc = 1'b0;
    #2 reset = 1'b0;

    // Reset values, with stimulus active during reset.
    repeat (2) @(posedge clk);
    #1;
    bus.output_enable = 1'b1;
    bus.tvalid = 1'b1;
    @(negedge clk);
    chk("rst_tready", {201'd0, bus.tready}, 202'd0);
    chk("rst_dout", bus.dout, 202'd0);
    chk("rst_dout_valid", {201'd0, bus.dout_valid}, 202'd0);
    chk("rst_oq", {197'd0, bus.oq}, 202'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.tvalid = 1'b0;
    @(posedge clk);
    #1;
    chk("rel_tready", {201'd0, bus.tready}, 202'd1);
    chk("rel_dout_valid", {201'd0, bus.dout_valid}, 202'd0);

    // 3-beat packet, data 50/51/52, mask AF.
    setup_pkt(3, 32, {$urandom(), $urandom(), $urandom(), 8'hAF, 24'($urandom())});
    for (int b = 0; b < 3; b++) beat_data[b] = 256'(50 + b);
    model_push();
    words_seen = 0;
    drive(0, 100, 100, 3);
    drain(100);
    chk("af_words", 202'(words_seen), 202'd5);
    chk("af_oq", {197'd0, bus.oq}, {197'd0, 5'b10011});

    // Mask EA.
    setup_pkt(2, 1 + $urandom_range(31), {$urandom(), $urandom(), $urandom(), 8'hEA, 24'($urandom())});
    model_push();
    drive(0, 100, 100, 2);
    drain(100);
    chk("ea_oq", {197'd0, bus.oq}, {197'd0, 5'b11000});

    // 1-beat packet, all bytes valid.
    setup_pkt(1, 32, {$urandom(), $urandom(), $urandom(), $urandom()});
    model_push();
    words_seen = 0;
    drive(0, 100, 100, 1);
    drain(100);
    chk("one_full_words", 202'(words_seen), 202'd3);
    chk("one_full_oq", {197'd0, bus.oq}, {197'd0, oq_exp(user)});

    // 1-beat packet, 20 bytes.
    setup_pkt(1, 20, {$urandom(), $urandom(), $urandom(), $urandom()});
    model_push();
    words_seen = 0;
    drive(0, 100, 100, 1);
    drain(100);
    chk("one_20_words", 202'(words_seen), 202'd2);

    // Stall: first beat taken with output_enable low, then ready must drop.
    setup_pkt(3, 32, {$urandom(), $urandom(), $urandom(), $urandom()});
    model_push();
    words_seen = 0;
    bus.output_enable = 1'b0;
    bus.tvalid = 1'b1;
    bus.tdata = beat_data[0];
    bus.tstrb = 32'hFFFF_FFFF;
    bus.tlast = 1'b0;
    bus.tuser = user;
    cycle();
    chk("stall_first_acc", {201'd0, acc}, 202'd1);
    bus.tdata = beat_data[1];
    cycle();
    chk("stall_tready", {201'd0, bus.tready}, 202'd0);
    chk("stall_no_acc", {201'd0, acc}, 202'd0);
    drive(1, 50, 100, 3);
    drain(50);
    chk("stall_words", 202'(words_seen), 202'd5);

    // Random back-to-back packets with random stalls on both sides.
    for (int p = 0; p < 25; p++) begin
      setup_pkt(1 + $urandom_range(5), 1 + $urandom_range(31),
                {$urandom(), $urandom(), $urandom(), $urandom()});
      model_push();
      drive(0, 70, 70, nb);
      if ($urandom_range(1) == 0) drain(60);
    end
    drain(60);
    chk("rand_oq", {197'd0, bus.oq}, {197'd0, oq_exp(user)});

    // Reset in the middle of a packet.
    setup_pkt(4, 32, {$urandom(), $urandom(), $urandom(), $urandom()});
    model_push();
    drive(0, 60, 100, 2);
    reset = 1'b0;
    bus.output_enable = 1'b1;
    exp_q.delete();
    last_dout = '0;
    #1;
    chk("mid_rst_tready", {201'd0, bus.tready}, 202'd0);
    chk("mid_rst_valid", {201'd0, bus.dout_valid}, 202'd0);
    chk("mid_rst_dout", bus.dout, 202'd0);
    chk("mid_rst_oq", {197'd0, bus.oq}, 202'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    setup_pkt(2, 1 + $urandom_range(31), {$urandom(), $urandom(), $urandom(), $urandom()});
    model_push();
    drive(0, 80, 100, 2);
    drain(80);
    chk("post_rst_oq", {197'd0, bus.oq}, {197'd0, oq_exp(user)});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi2fifo.md
AXI2FIFO -- requirements
Module: axi2fifo

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 The block SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 tvalid  input  1  AXI-Stream beat valid.
REQ-006 tready  output  1  AXI-Stream beat ready.
REQ-007 tdata  input  256  beat data; byte 0 in tdata[7:0], byte 0 goes first.
REQ-008 tstrb  input  32  byte enables; contiguous from bit 0; all ones except on the last beat.
REQ-009 tuser  input  128  packet metadata, sampled on the first beat; tuser[31:24] is the destination-port mask.
REQ-010 tlast  input  1  last beat of packet.
REQ-011 output_enable  input  1  downstream can accept a word this cycle.
REQ-012 dout  output  202  memory word.
REQ-013 dout_valid  output  1  write strobe for dout.
REQ-014 oq  output  5  one-hot output-queue mask of the current packet.

Function
REQ-015 dout word layout:
- [201:10] payload
- [9:5] valid byte count of the word
- [4:2] tag
- [1] last word of packet
- [0] always 0
REQ-016 Per packet, a header word SHALL be emitted first, then data words.
REQ-017 Header word:
- tag 0, dout[137:10]=tuser, dout[201:138]=0
- count 16
- bit1=0
REQ-018 Data repacking: three 256-bit beats b0,b1,b2 SHALL map to four 192-bit words, phases cycling 1,2,3,4 then back to 1:
- tag1: payload=b0[191:0]
- tag2: [73:10]=b0[255:192], [201:74]=b1[127:0]
- tag3: [137:10]=b1[255:128], [201:138]=b2[63:0]
- tag4: payload=b2[255:64]
REQ-019 Byte count SHALL be min(24, packet bytes not yet emitted); unused payload bits SHALL be 0.
REQ-020 Last-beat byte count SHALL be the number of ones in tstrb (1..32).
REQ-021 Words SHALL be emitted only while packet bytes remain; empty words are never emitted.
REQ-022 The final data word SHALL carry bit1=1, including a residual-only flush word.
REQ-023 After tlast, the phase SHALL restart at tag1 and the next packet starts with a header.
REQ-024 At most one word SHALL be emitted per cycle, and only when output_enable=1; dout_valid=1 exactly in emitting cycles.
REQ-025 dout SHALL hold its value when not emitting.
REQ-026 A beat is accepted when tvalid and tready are both 1.
REQ-027 tready SHALL be 1 only when no words of earlier beats are pending, or exactly one is pending and is emitted this cycle.
REQ-028 No beat or word SHALL be lost or duplicated under any output_enable pattern.
REQ-029 oq SHALL be updated when the header word is emitted and held until the next header:
- oq[i]=tuser[24+2i] for i=0..3
- oq[4]=OR of tuser[25],[27],[29],[31]
REQ-030 If output_enable and tvalid are both low, state SHALL be held; stalls may occur mid-packet at any phase.

Reset
REQ-031 While reset=0, outputs SHALL be: tready=0, dout=0, dout_valid=0, oq=0.
REQ-032 Reset SHALL clear the phase to header-pending and discard any pending words.
REQ-033 Mid-packet reset SHALL drop the partial packet; after release, the next accepted beat is treated as a first beat.
REQ-034 tready SHALL go to 1 in the first cycle after reset release.

Verification
REQ-035 Reset: assert reset -> all outputs 0; release -> tready=1 the next cycle, dout_valid=0.
REQ-036 3-beat packet, tdata 50,51,52, tuser[31:24]=8'hAF, output_enable=1:
- words tag0,1,2,3,4, counts 16,24,24,24,24
- tlast bit set only on the tag4 word
- oq=5'b10011
REQ-037 Packet with tuser[31:24]=8'hEA -> oq=5'b11000.
REQ-038 1-beat packet, tstrb all ones -> header, then tag1 (count 24), then tag2 (count 8, [73:10]=tdata[255:192], bit1=1).
REQ-039 1-beat packet, tstrb=32'h000fffff -> header, then tag1 with count 20 and bit1=1; no further words.
REQ-040 output_enable toggled 0/1 mid-packet -> dout_valid only when output_enable=1, tready drops while words are pending, and the word sequence is identical to the unstalled run.
